// File: rtl/bldcm_commutator_pkg.sv
// Shared constants and lookups for the BLDC six-step commutator.
// Holds the FSM state encoding, the fault codes, the Hall-to-sector
// decode, the reverse-direction sector shift and the drive-pattern tables.
package bldcm_commutator_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StBrake = 2'd2,
    StFault = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FaultNone        = 2'd0,
    FaultInvalidHall = 2'd1,
    FaultStall       = 2'd2,
    FaultIllegalJump = 2'd3
  } fault_t;

  // Hall codes 0 and 7 cannot come from a healthy sensor set.
  function automatic logic hallIsValid(input logic [2:0] code);
    return (code != 3'd0) && (code != 3'd7);
  endfunction

  // Hall code {C,B,A} to rotor sector 0..5; invalid codes map to 0 and
  // must be qualified with hallIsValid by the caller.
  function automatic logic [2:0] hallToSector(input logic [2:0] code);
    logic [2:0] sector;
    case (code)
      3'd5:    sector = 3'd0;
      3'd4:    sector = 3'd1;
      3'd6:    sector = 3'd2;
      3'd2:    sector = 3'd3;
      3'd3:    sector = 3'd4;
      3'd1:    sector = 3'd5;
      default: sector = 3'd0;
    endcase
    return sector;
  endfunction

  // Reverse rotation drives the pattern half a turn ahead: (s+3) mod 6.
  function automatic logic [2:0] driveSector(input logic [2:0] sector,
                                             input logic       reverse);
    logic [2:0] shifted;
    shifted = (sector >= 3'd3) ? (sector - 3'd3) : (sector + 3'd3);
    return reverse ? shifted : sector;
  endfunction

  // High-side phase per drive sector, one-hot {C,B,A}.
  function automatic logic [2:0] patternHigh(input logic [2:0] sector);
    logic [2:0] high;
    case (sector)
      3'd0, 3'd1: high = 3'b001;
      3'd2, 3'd3: high = 3'b010;
      3'd4, 3'd5: high = 3'b100;
      default:    high = 3'b000;
    endcase
    return high;
  endfunction

  // Low-side phase per drive sector, one-hot {C,B,A}.
  function automatic logic [2:0] patternLow(input logic [2:0] sector);
    logic [2:0] low;
    case (sector)
      3'd0:       low = 3'b010;
      3'd1, 3'd2: low = 3'b100;
      3'd3, 3'd4: low = 3'b001;
      3'd5:       low = 3'b010;
      default:    low = 3'b000;
    endcase
    return low;
  endfunction

  // True when sector a is one step either side of sector b (mod 6).
  function automatic logic sectorsAdjacent(input logic [2:0] a,
                                           input logic [2:0] b);
    logic [2:0] nextB;
    logic [2:0] prevB;
    nextB = (b == 3'd5) ? 3'd0 : (b + 3'd1);
    prevB = (b == 3'd0) ? 3'd5 : (b - 3'd1);
    return (a == nextB) || (a == prevB);
  endfunction

endpackage

// File: rtl/bldcm_commutator_hall_filter.sv
// Hall sensor conditioning for the commutator.
// A 2-FF synchroniser brings the raw Hall bits into the clock domain, then a
// stability filter accepts a code only after it has been seen on
// pHallFilterCycles consecutive synchronised samples.
// Ports:
//   iClock, iReset_n  clock and synchronous active-low reset
//   hall_i            raw asynchronous Hall inputs {C,B,A}
//   code_o            last accepted Hall code
//   codeValid_o       a code has been accepted since reset
//   hallEdge_o        one-cycle strobe when the accepted code changes
module bldcm_hall_filter #(
  parameter int unsigned pHallFilterCycles = 32'd4
) (
  input  logic       iClock,
  input  logic       iReset_n,
  input  logic [2:0] hall_i,
  output logic [2:0] code_o,
  output logic       codeValid_o,
  output logic       hallEdge_o
);

  localparam int unsigned CntW = $clog2(pHallFilterCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(pHallFilterCycles - 1);

  logic [2:0]      sync1_q, sync2_q;
  logic            sync1Valid_q, sync2Valid_q;
  logic [2:0]      cand_q, cand_d;
  logic            candValid_q, candValid_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      code_q, code_d;
  logic            codeValid_q, codeValid_d;
  logic            edge_q, edge_d;

  // Synchroniser. The valid bits stop the reset contents of the two flops
  // from being mistaken for real Hall samples.
  always_ff @(posedge iClock) begin
    if (!iReset_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      sync1Valid_q <= 1'b0;
      sync2Valid_q <= 1'b0;
    end else begin
      sync1_q      <= hall_i;
      sync2_q      <= sync1_q;
      sync1Valid_q <= 1'b1;
      sync2Valid_q <= sync1Valid_q;
    end
  end

  // Stability filter. The counter holds (samples seen - 1) for the current
  // candidate and saturates at the last count; reaching it accepts the
  // candidate. Re-accepting the same code raises no edge.
  always_comb begin
    cand_d      = cand_q;
    candValid_d = candValid_q;
    cnt_d       = cnt_q;
    code_d      = code_q;
    codeValid_d = codeValid_q;
    edge_d      = 1'b0;
    if (sync2Valid_q) begin
      if (!candValid_q || (sync2_q != cand_q)) begin
        cand_d      = sync2_q;
        candValid_d = 1'b1;
        cnt_d       = '0;
      end else if (cnt_q != CntLast) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (cnt_d == CntLast) begin
        code_d      = sync2_q;
        codeValid_d = 1'b1;
        edge_d      = !codeValid_q || (sync2_q != code_q);
      end
    end
  end

  // Filter state registers.
  always_ff @(posedge iClock) begin
    if (!iReset_n) begin
      cand_q      <= '0;
      candValid_q <= 1'b0;
      cnt_q       <= '0;
      code_q      <= '0;
      codeValid_q <= 1'b0;
      edge_q      <= 1'b0;
    end else begin
      cand_q      <= cand_d;
      candValid_q <= candValid_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      codeValid_q <= codeValid_d;
      edge_q      <= edge_d;
    end
  end

  assign code_o      = code_q;
  assign codeValid_o = codeValid_q;
  assign hallEdge_o  = edge_q;

endmodule

// File: rtl/bldcm_commutator.sv
// Six-step BLDC commutation stage.
// Filters the Hall sensors, decodes the rotor sector, and issues registered
// per-phase high/low switch requests (high side gated by PWM). Detects
// invalid Hall codes, illegal sector jumps and stall. No dead time is added
// here; the downstream on-delay stages handle that.
// Ports:
//   iClock, iReset_n     clock and synchronous active-low reset
//   iEnable, iDirection  drive enable, 0 forward / 1 reverse
//   iBrake, iPwm         low-side brake request, PWM carrier
//   iHall                raw Hall inputs {C,B,A}
//   iFaultClear          fault acknowledge (honoured only with iEnable=0)
//   oHighReq, oLowReq    switch requests {C,B,A}
//   oSector, oHallEdge   decoded sector, accepted-change pulse
//   oFault, oFaultCode   latched fault and its cause
module bldcm_commutator
  import bldcm_commutator_pkg::*;
#(
  parameter int unsigned pHallFilterCycles = 32'd4,
  parameter int unsigned pStallCycles      = 32'd1000000
) (
  input  logic       iClock,
  input  logic       iReset_n,
  input  logic       iEnable,
  input  logic       iDirection,
  input  logic       iBrake,
  input  logic       iPwm,
  input  logic [2:0] iHall,
  input  logic       iFaultClear,
  output logic [2:0] oHighReq,
  output logic [2:0] oLowReq,
  output logic [2:0] oSector,
  output logic       oHallEdge,
  output logic       oFault,
  output logic [1:0] oFaultCode
);

  localparam int unsigned StallW = $clog2(pStallCycles + 1);
  localparam logic [StallW-1:0] StallLimit = StallW'(pStallCycles);

  logic [2:0]        acceptedCode;
  logic              acceptedValid;
  logic              hallEdge;
  logic              codeOk;
  logic [2:0]        sectorNow;
  logic [2:0]        driveSec;
  fault_t            faultNow;
  logic              faultHit;

  state_t            state_q, state_d;
  logic [StallW-1:0] stallCnt_q, stallCnt_d;
  logic              prevValid_q, prevValid_d;
  logic [2:0]        prevSector_q, prevSector_d;
  logic [2:0]        highReq_q, highReq_d;
  logic [2:0]        lowReq_q, lowReq_d;
  logic [2:0]        sector_q, sector_d;
  logic              hallEdge_q;
  logic              fault_q, fault_d;
  fault_t            faultCode_q, faultCode_d;

  bldcm_hall_filter #(
    .pHallFilterCycles(pHallFilterCycles)
  ) uHallFilter (
    .iClock     (iClock),
    .iReset_n   (iReset_n),
    .hall_i     (iHall),
    .code_o     (acceptedCode),
    .codeValid_o(acceptedValid),
    .hallEdge_o (hallEdge)
  );

  assign codeOk    = acceptedValid && hallIsValid(acceptedCode);
  assign sectorNow = hallToSector(acceptedCode);
  assign driveSec  = driveSector(sectorNow, iDirection);

  // Fault detection, highest priority first. The jump check is skipped
  // until a valid sector has been seen since reset or since leaving FAULT.
  always_comb begin
    faultNow = FaultNone;
    if (state_q != StFault) begin
      if (hallEdge && !hallIsValid(acceptedCode)) begin
        faultNow = FaultInvalidHall;
      end else if (hallEdge && prevValid_q &&
                   !sectorsAdjacent(sectorNow, prevSector_q)) begin
        faultNow = FaultIllegalJump;
      end else if ((state_q == StRun) && (stallCnt_q == StallLimit)) begin
        faultNow = FaultStall;
      end
    end
  end

  assign faultHit = (faultNow != FaultNone);

  // State register.
  always_ff @(posedge iClock) begin
    if (!iReset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A fault wins over brake and disable in the same cycle.
  always_comb begin
    state_d = state_q;
    if (faultHit) begin
      state_d = StFault;
    end else begin
      case (state_q)
        StIdle: begin
          if (iBrake) begin
            state_d = StBrake;
          end else if (iEnable && codeOk) begin
            state_d = StRun;
          end
        end
        StRun: begin
          if (iBrake) begin
            state_d = StBrake;
          end else if (!iEnable) begin
            state_d = StIdle;
          end
        end
        StBrake: begin
          if (!iBrake) begin
            state_d = StIdle;
          end
        end
        StFault: begin
          if (iFaultClear && !iEnable) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output logic. Requests follow the current state one cycle later and are
  // forced off in the cycle a fault is registered. The fault code is kept
  // only while the machine stays in FAULT.
  always_comb begin
    highReq_d = '0;
    lowReq_d  = '0;
    if (!faultHit) begin
      case (state_q)
        StRun: begin
          highReq_d = patternHigh(driveSec) & {3{iPwm}};
          lowReq_d  = patternLow(driveSec);
        end
        StBrake: lowReq_d = 3'b111;
        default: ;
      endcase
    end
    fault_d = (state_d == StFault);
    if (faultHit) begin
      faultCode_d = faultNow;
    end else if (state_d == StFault) begin
      faultCode_d = faultCode_q;
    end else begin
      faultCode_d = FaultNone;
    end
  end

  // Sector, stall and previous-sector bookkeeping. The stall counter only
  // runs in RUN and restarts on each visible Hall edge pulse.
  always_comb begin
    sector_d     = codeOk ? sectorNow : sector_q;
    prevValid_d  = prevValid_q;
    prevSector_d = prevSector_q;
    if ((state_q != StRun) || hallEdge_q) begin
      stallCnt_d = '0;
    end else if (stallCnt_q != StallLimit) begin
      stallCnt_d = stallCnt_q + 1'b1;
    end else begin
      stallCnt_d = stallCnt_q;
    end
    if ((state_q == StFault) || faultHit) begin
      prevValid_d = 1'b0;
    end else if (hallEdge && codeOk) begin
      prevValid_d  = 1'b1;
      prevSector_d = sectorNow;
    end
  end

  // Output and bookkeeping registers.
  always_ff @(posedge iClock) begin
    if (!iReset_n) begin
      highReq_q    <= '0;
      lowReq_q     <= '0;
      sector_q     <= '0;
      hallEdge_q   <= 1'b0;
      fault_q      <= 1'b0;
      faultCode_q  <= FaultNone;
      stallCnt_q   <= '0;
      prevValid_q  <= 1'b0;
      prevSector_q <= '0;
    end else begin
      highReq_q    <= highReq_d;
      lowReq_q     <= lowReq_d;
      sector_q     <= sector_d;
      hallEdge_q   <= hallEdge;
      fault_q      <= fault_d;
      faultCode_q  <= faultCode_d;
      stallCnt_q   <= stallCnt_d;
      prevValid_q  <= prevValid_d;
      prevSector_q <= prevSector_d;
    end
  end

  assign oHighReq   = highReq_q;
  assign oLowReq    = lowReq_q;
  assign oSector    = sector_q;
  assign oHallEdge  = hallEdge_q;
  assign oFault     = fault_q;
  assign oFaultCode = faultCode_q;

endmodule
